verify_scheduler: RTL and testbench



---
 rtl/verify_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/verify_scheduler.sv | 150 +++++++++++++++
 tb/tb_verify_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verify_pkg.sv
// Shared definitions for the verification scheduler: FSM encoding, field widths, key tag.
package verify_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StHash,
    StResp
  } state_t;

  localparam int unsigned PUBKEY_W = 11;
  localparam int unsigned KEY_W = 8;
  localparam logic [2:0] KEY_TAG_DEFAULT = 3'b010;
  localparam logic [2:0] HASH_DONE_CNT = 3'b111;

  // Tag field of a public key; the low byte is the expected hash.
  function automatic logic [2:0] key_tag(input logic [PUBKEY_W-1:0] pk);
    return pk[PUBKEY_W-1:KEY_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after pointer.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  int unsigned idx;
  logic        found;

  // Scan from the pointer with wrap-around; the first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    any_req   = |req;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (int'(pointer) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/verify_scheduler.sv
// Shares one pearson_hash8 between NUM_REQ requesters with round-robin arbitration.
// Optional hash abort counter is built when VERIFY_TIMEOUT_EN is defined.
module verify_scheduler
  import verify_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter logic [2:0]  KEY_TAG = KEY_TAG_DEFAULT,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*PUBKEY_W-1:0] public_key_bus,
  input  logic [NUM_REQ*KEY_W-1:0]  input_key_bus,
  output logic [NUM_REQ-1:0]        done,
  output logic                      correct,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic [KEY_W-1:0]          hash_message,
  output logic                      hash_reset_n,
`ifdef VERIFY_TIMEOUT_EN
  output logic                      timeout,
`endif
  input  logic [KEY_W-1:0]          hash_value,
  input  logic [2:0]                hash_counter
);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [KEY_W-1:0]   expect_q;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               any_req;
  logic [PUBKEY_W-1:0] pub_sel;
  logic [KEY_W-1:0]   key_sel;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   next_ptr;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req      (req),
    .pointer  (rr_ptr),
    .grant    (arb_grant),
    .grant_idx(arb_idx),
    .any_req  (any_req)
  );

  // Pick the winning requester's key fields off the buses.
  always_comb begin
    pub_sel = '0;
    key_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        pub_sel = public_key_bus[i*PUBKEY_W +: PUBKEY_W];
        key_sel = input_key_bus[i*KEY_W +: KEY_W];
      end
    end
  end

  // Done strobe and pointer advance for the requester currently being served.
  always_comb begin
    grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    next_ptr     = (grant_id == IDX_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
  end

`ifdef VERIFY_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  // TIMEOUT only matters when the abort counter is built.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Sequencer: grant, restart the hash, wait for completion, strobe the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= StIdle;
      done         <= '0;
      correct      <= 1'b0;
      busy         <= 1'b0;
      grant_id     <= '0;
      rr_ptr       <= '0;
      hash_reset_n <= 1'b0;
      hash_message <= '0;
      expect_q     <= '0;
`ifdef VERIFY_TIMEOUT_EN
      timeout      <= 1'b0;
      tmo_cnt      <= '0;
`endif
    end else begin
      done <= '0;
`ifdef VERIFY_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          hash_reset_n <= 1'b0;
          if (any_req) begin
            grant_id     <= arb_idx;
            expect_q     <= pub_sel[KEY_W-1:0];
            hash_message <= key_sel;
            busy         <= 1'b1;
            if (key_tag(pub_sel) != KEY_TAG) begin
              // Unverifiable key: answer immediately without touching the hash.
              correct <= 1'b0;
              done    <= arb_grant;
              state   <= StResp;
            end else begin
              state <= StLoad;
            end
          end
        end
        StLoad: begin
          hash_reset_n <= 1'b1;
          state        <= StHash;
`ifdef VERIFY_TIMEOUT_EN
          tmo_cnt      <= '0;
`endif
        end
        StHash: begin
          if (hash_counter == HASH_DONE_CNT) begin
            correct <= (hash_value == expect_q);
            done    <= grant_onehot;
            state   <= StResp;
`ifdef VERIFY_TIMEOUT_EN
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            correct <= 1'b0;
            done    <= grant_onehot;
            timeout <= 1'b1;
            state   <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end
        StResp: begin
          hash_reset_n <= 1'b0;
          busy         <= 1'b0;
          rr_ptr       <= next_ptr;
          state        <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_verify_scheduler.sv
// Scoreboard bench for verify_scheduler with a behavioural pearson_hash8 stand-in.
// Timeout scenario runs only when VERIFY_TIMEOUT_EN is defined.
module tb_verify_scheduler;

  logic        clock;
  logic        reset;
  logic [3:0]  req;
  logic [43:0] public_key_bus;
  logic [31:0] input_key_bus;
  logic [3:0]  done;
  logic        correct;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  hash_message;
  logic        hash_reset_n;
  logic [7:0]  hash_value;
  logic [2:0]  hash_counter;
`ifdef VERIFY_TIMEOUT_EN
  logic        timeout;
`endif

  verify_scheduler #(
    .NUM_REQ(4),
    .KEY_TAG(3'b010),
    .TIMEOUT(16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .public_key_bus(public_key_bus),
    .input_key_bus (input_key_bus),
    .done          (done),
    .correct       (correct),
    .busy          (busy),
    .grant_id      (grant_id),
    .hash_message  (hash_message),
    .hash_reset_n  (hash_reset_n),
`ifdef VERIFY_TIMEOUT_EN
    .timeout       (timeout),
`endif
    .hash_value    (hash_value),
    .hash_counter  (hash_counter)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hash stand-in: counter clears while held in restart, counts up to 7, result at 7.
  logic [2:0] hcnt;
  logic       stuck;
  logic [7:0] hash_ret;
  always_ff @(posedge clock) begin
    if (!hash_reset_n) hcnt <= 3'd0;
    else if (stuck) hcnt <= 3'b010;
    else if (hcnt != 3'd7) hcnt <= hcnt + 3'd1;
  end
  assign hash_counter = hcnt;
  assign hash_value = (hcnt == 3'd7) ? hash_ret : 8'h00;

  typedef struct {
    logic [3:0] d;
    logic       c;
    logic [1:0] id;
    int         lat;
    logic       hashed;
    logic [7:0] msg;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input logic [3:0] d, input logic c, input logic [1:0] id,
                            input int lat, input logic hashed, input logic [7:0] msg,
                            input logic tmo);
    exp_t e;
    e.d = d; e.c = c; e.id = id; e.lat = lat; e.hashed = hashed; e.msg = msg; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic set_keys(input int i, input logic [10:0] pk, input logic [7:0] ik);
    public_key_bus[i*11 +: 11] = pk;
    input_key_bus[i*8 +: 8] = ik;
  endtask

  // Wait for done[i], bounded; on success the request is dropped.
  task automatic wait_done(input int i, input int budget);
    int n = 0;
    while (done[i] !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (done[i] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_wait[%0d]: got no done expected done within %0d cycles", i, budget);
    end
    req[i] = 1'b0;
  endtask

  // Monitor: tracks grant-to-done latency and hash activity, pops the scoreboard on done.
  int         cyc = 0;
  int         last_idle = 0;
  logic       hash_seen = 1'b0;
  logic [7:0] seen_msg = 8'h00;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!busy) begin
        last_idle = cyc;
        hash_seen = 1'b0;
      end
      if (hash_reset_n === 1'b1) begin
        hash_seen = 1'b1;
        seen_msg = hash_message;
      end
      if (done !== 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("done", 32'(done), 32'(e.d));
          chk("correct", 32'(correct), 32'(e.c));
          chk("grant_id", 32'(grant_id), 32'(e.id));
          chk("latency", 32'(cyc - last_idle), 32'(e.lat));
          chk("hash_started", 32'(hash_seen), 32'(e.hashed));
          if (e.hashed) chk("hash_message", 32'(seen_msg), 32'(e.msg));
`ifdef VERIFY_TIMEOUT_EN
          chk("timeout", 32'(timeout), 32'(e.tmo));
`endif
        end
      end
    end
  end

  initial begin
    int served;
    int n;
    logic re0_pending;
    logic re0_done;
    reset = 1'b1;
    req = '0;
    public_key_bus = '0;
    input_key_bus = '0;
    hash_ret = 8'h00;
    stuck = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_correct", 32'(correct), 32'h0);
    chk("reset_grant_id", 32'(grant_id), 32'h0);
    chk("reset_hash_reset_n", 32'(hash_reset_n), 32'h0);
    chk("reset_hash_message", 32'(hash_message), 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Key matches; bus is scrambled after grant to show the inputs were latched.
    set_keys(0, 11'h2A5, 8'h3C);
    hash_ret = 8'hA5;
    expect_txn(4'b0001, 1'b1, 2'd0, 10, 1'b1, 8'h3C, 1'b0);
    req = 4'b0001;
    repeat (2) @(negedge clock);
    set_keys(0, 11'h000, 8'hFF);
    wait_done(0, 40);
    @(negedge clock);

    // Hash mismatch.
    set_keys(0, 11'h2A5, 8'h3C);
    hash_ret = 8'hA4;
    expect_txn(4'b0001, 1'b0, 2'd0, 10, 1'b1, 8'h3C, 1'b0);
    req = 4'b0001;
    wait_done(0, 40);
    @(negedge clock);

    // Bad tag: answered one cycle after grant, hash never released.
    set_keys(1, 11'h6A5, 8'h3C);
    expect_txn(4'b0010, 1'b0, 2'd1, 1, 1'b0, 8'h00, 1'b0);
    req = 4'b0010;
    wait_done(1, 40);
    @(negedge clock);

    // Single request to 3 brings the pointer back to 0.
    set_keys(3, 11'h2A5, 8'h11);
    hash_ret = 8'hA5;
    expect_txn(4'b1000, 1'b1, 2'd3, 10, 1'b1, 8'h11, 1'b0);
    req = 4'b1000;
    wait_done(3, 40);
    @(negedge clock);

    // Contention: all four requesting, requester 0 comes back after its done.
    set_keys(0, 11'h2A5, 8'h01);
    set_keys(1, 11'h6A5, 8'h02);
    set_keys(2, 11'h2A4, 8'h03);
    set_keys(3, 11'h2A5, 8'h04);
    expect_txn(4'b0001, 1'b1, 2'd0, 10, 1'b1, 8'h01, 1'b0);
    expect_txn(4'b0010, 1'b0, 2'd1, 1, 1'b0, 8'h00, 1'b0);
    expect_txn(4'b0100, 1'b0, 2'd2, 10, 1'b1, 8'h03, 1'b0);
    expect_txn(4'b1000, 1'b1, 2'd3, 10, 1'b1, 8'h04, 1'b0);
    expect_txn(4'b0001, 1'b1, 2'd0, 10, 1'b1, 8'h01, 1'b0);
    req = 4'b1111;
    served = 0;
    n = 0;
    re0_pending = 1'b0;
    re0_done = 1'b0;
    while (served < 5 && n < 200) begin
      @(negedge clock);
      n++;
      if (re0_pending) begin
        req[0] = 1'b1;
        re0_pending = 1'b0;
      end
      if (done !== 4'b0000) begin
        served++;
        req = req & ~done;
        if (done[0] && !re0_done) begin
          re0_done = 1'b1;
          re0_pending = 1'b1;
        end
      end
    end
    chk("contention_served", 32'(served), 32'd5);
    req = '0;
    @(negedge clock);

    // Reset while hashing aborts without a done strobe.
    set_keys(0, 11'h2A5, 8'h3C);
    expect_txn(4'b0001, 1'b1, 2'd0, 10, 1'b1, 8'h3C, 1'b0);
    req = 4'b0001;
    n = 0;
    while (hcnt != 3'd3 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("reached_count3", 32'(hcnt), 32'd3);
    reset = 1'b1;
    req = '0;
    sb.delete();
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_hash_reset_n", 32'(hash_reset_n), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    set_keys(2, 11'h2A5, 8'h77);
    expect_txn(4'b0100, 1'b1, 2'd2, 10, 1'b1, 8'h77, 1'b0);
    req = 4'b0100;
    wait_done(2, 40);
    @(negedge clock);

`ifdef VERIFY_TIMEOUT_EN
    // Hash never completes: abort after 16 HASH cycles.
    stuck = 1'b1;
    set_keys(0, 11'h2A5, 8'h3C);
    expect_txn(4'b0001, 1'b0, 2'd0, 18, 1'b1, 8'h3C, 1'b1);
    req = 4'b0001;
    wait_done(0, 60);
    stuck = 1'b0;
    @(negedge clock);
`endif

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
